// File: rtl/credit_display_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit multiplexed display scan.
// Optional leading-zero blanking when CREDIT_DISPLAY_BLANK_EN is defined.
module credit_display_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int BIN_W    = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value_in,
  input  logic             load,
  output logic             busy,
  output logic [3:0]       digit,
  output logic [3:0]       anode
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam int ITER_W = $clog2(BIN_W);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(SCAN_DIV - 1);

  state_t            state;
  logic [ITER_W-1:0] iter;
  logic [BIN_W-1:0]  bin_sr;
  logic [15:0]       bcd_sr;
  logic [3:0][3:0]   disp;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        scan_idx;

  logic [15:0]       bcd_adj;
  logic [15:0]       bcd_shift;
  logic [BIN_W-1:0]  bin_shift;
  logic [BIN_W-1:0]  value_sat;

  // Four BCD digits top out at 9999; anything larger is clamped before conversion.
  always_comb begin
    value_sat = value_in;
    if (32'(value_in) > 32'd9999) value_sat = BIN_W'(9999);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    {bcd_shift, bin_shift} = {bcd_adj, bin_sr} << 1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      iter   <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
      disp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin_sr <= value_sat;
            bcd_sr <= '0;
            iter   <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          bin_sr <= bin_shift;
          bcd_sr <= bcd_shift;
          iter   <= iter + 1'b1;
          if (iter == LAST_ITER) begin
            // Only the finished result ever reaches the display registers.
            disp  <= bcd_shift;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running scan, independent of conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else if (div_cnt == LAST_DIV) begin
      div_cnt  <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef CREDIT_DISPLAY_BLANK_EN
  logic [1:0] msd;
  logic       blank;

  // Positions above the most significant non-zero digit are switched off; units always shows.
  always_comb begin
    msd = 2'd0;
    if (disp[1] != 4'h0) msd = 2'd1;
    if (disp[2] != 4'h0) msd = 2'd2;
    if (disp[3] != 4'h0) msd = 2'd3;
    blank = (scan_idx > msd);
    anode = ~(4'b0001 << scan_idx);
    digit = disp[scan_idx];
    if (blank) begin
      anode = 4'hF;
      digit = 4'hF;
    end
  end
`else
  always_comb begin
    anode = ~(4'b0001 << scan_idx);
    digit = disp[scan_idx];
  end
`endif

endmodule

// File: tb/tb_credit_display_scanner.sv
// Self-checking bench for credit_display_scanner: table-driven loads, scoreboard of expected BCD
// results popped when busy falls, and a scan model checked slot by slot.
module tb_credit_display_scanner;

  localparam int SCAN_DIV = 4;
  localparam int BIN_W    = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [BIN_W-1:0] value_in = '0;
  logic             busy;
  logic [3:0]       digit;
  logic [3:0]       anode;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] shown = 16'h0;
  int          busy_len = 0;
  logic        prev_busy = 1'b0;
  int          scan_cnt = 0;

  typedef struct {
    string            name;
    logic [BIN_W-1:0] val;
    logic [15:0]      bcd;
  } vec_t;

  vec_t vecs[9];

  credit_display_scanner #(.SCAN_DIV(SCAN_DIV), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
    .busy(busy), .digit(digit), .anode(anode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan position model: one position per SCAN_DIV clocks since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_cnt <= 0;
    else        scan_cnt <= scan_cnt + 1;
  end

  // Scoreboard consumer: a finished conversion must match the oldest accepted load.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      shown     = 16'h0;
      busy_len  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) busy_len++;
      if (prev_busy && !busy) begin
        check("busy_len", busy_len, BIN_W);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got a completed conversion, required none");
        end else begin
          shown = exp_q.pop_front();
        end
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  function automatic void exp_slot(input logic [15:0] d, input int idx,
                                   output logic [3:0] an, output logic [3:0] dg);
    an = ~(4'b0001 << idx);
    dg = d[4*idx +: 4];
`ifdef CREDIT_DISPLAY_BLANK_EN
    begin
      int top;
      top = 0;
      for (int i = 1; i < 4; i++) if (d[4*i +: 4] != 4'h0) top = i;
      if (idx > top) begin
        an = 4'hF;
        dg = 4'hF;
      end
    end
`endif
  endfunction

  task automatic check_display(input string name, input int ncyc);
    logic [3:0] ea, ed;
    int idx;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      idx = (scan_cnt / SCAN_DIV) % 4;
      exp_slot(shown, idx, ea, ed);
      check($sformatf("%s_anode_pos%0d", name, idx), anode, ea);
      check($sformatf("%s_digit_pos%0d", name, idx), digit, ed);
    end
  endtask

  task automatic do_load(input logic [BIN_W-1:0] v, input logic [15:0] e, input bit accept);
    @(negedge clk);
    value_in = v;
    load = 1'b1;
    if (accept) exp_q.push_back(e);
    @(negedge clk);
    load = 1'b0;
    if (accept) check("busy_rise", busy, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"v1234",  14'd1234,  16'h1234};
    vecs[1] = '{"v12000", 14'd12000, 16'h9999};
    vecs[2] = '{"v9999",  14'd9999,  16'h9999};
    vecs[3] = '{"v0",     14'd0,     16'h0000};
    vecs[4] = '{"v7",     14'd7,     16'h0007};
    vecs[5] = '{"v305",   14'd305,   16'h0305};
    vecs[6] = '{"v16383", 14'd16383, 16'h9999};
    vecs[7] = '{"v10000", 14'd10000, 16'h9999};
    vecs[8] = '{"v5678",  14'd5678,  16'h5678};

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_anode", anode, 4'b1110);
    check("rst_digit", digit, 4'h0);
    rst_n = 1'b1;
    check("rel_anode", anode, 4'b1110);
    check("rel_digit", digit, 4'h0);
    check_display("post_reset", 17);

    foreach (vecs[i]) begin
      do_load(vecs[i].val, vecs[i].bcd, 1'b1);
      wait_idle();
      check_display(vecs[i].name, 16);
    end

    // Load during a conversion is dropped, display holds until completion.
    do_load(14'd42, 16'h0042, 1'b1);
    repeat (4) @(negedge clk);
    do_load(14'd7, 16'h0007, 1'b0);
    check_display("hold_old", 4);
    wait_idle();
    check_display("v42", 16);
    do_load(14'd7, 16'h0007, 1'b1);
    wait_idle();
    check_display("v7_after", 16);

    // Reset in the middle of a conversion, then a load in the first cycle after release.
    do_load(14'd5678, 16'h5678, 1'b1);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_anode", anode, 4'b1110);
    check("abort_digit", digit, 4'h0);
    repeat (3) @(negedge clk);
    value_in = 14'd5678;
    rst_n = 1'b1;
    load = 1'b1;
    exp_q.push_back(16'h5678);
    @(negedge clk);
    load = 1'b0;
    check("first_cycle_load_busy", busy, 1'b1);
    wait_idle();
    check_display("v5678_after_abort", 16);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
